// File: rtl/sys_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sys_monitor
// Brief    : Data-bus snooper with halt detection, saturating cycle/event
//            counters and a read-only register window. Optional watchdog
//            enabled by defining MONITOR_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sys_monitor #(
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 32,
    parameter int                NCNT      = 4,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0] MON_BASE  = ADDR_W'(24'hFFFF00),
    parameter int                DRAIN_CYC = 4,
    parameter int                WDOG_CYC  = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_clk_en,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic              i_dwr,
    input  logic [DATA_W-1:0] i_ddata,
    input  logic              i_drd,
    input  logic [NCNT-1:0]   i_event,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_halt,
    output logic [DATA_W-1:0] o_halt_code,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_WDOG   = 2'd3
    } state_t;

    localparam int                c_LAST_OFF   = NCNT + 1;
    localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;
    localparam logic [7:0]        c_DRAIN_LOAD = 8'(DRAIN_CYC);
    localparam logic [DATA_W-1:0] c_WDOG_CODE  = DATA_W'(32'hDEAD_0D06);

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_drain, w_drain_nxt;
    logic [DATA_W-1:0]   r_halt_code, w_code_nxt;
    logic [CNT_W-1:0]    r_cyc_cnt;
    logic [CNT_W-1:0]    r_ev_cnt [NCNT];
    logic [DATA_W-1:0]   r_rdata, w_rdata;
    logic                r_rvalid;

    logic [ADDR_W-1:0]   w_off;
    logic                w_in_win;
    logic                w_clear;
    logic                w_halt_req;
    logic                w_counting;
    logic                w_wdog_expire;

    assign w_off      = i_daddr - MON_BASE;
    assign w_in_win   = (i_daddr >= MON_BASE) && (w_off <= ADDR_W'(c_LAST_OFF));
    assign w_clear    = i_dwr && (i_daddr == MON_BASE);
    assign w_halt_req = i_dwr && (i_daddr == HALT_ADDR);
    assign w_counting = (r_state == ST_RUN) || (r_state == ST_DRAIN);

`ifdef MONITOR_WDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_CYC + 1);

    logic [c_WDOG_W-1:0] r_wdog;

    // Expiry is suppressed by a same-cycle clear, which restarts the count.
    assign w_wdog_expire = (r_state == ST_RUN) && !w_clear &&
                           (r_wdog == c_WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_wdog <= '0;
        end else if (i_clk_en) begin
            if (w_clear) begin
                r_wdog <= '0;
            end else if (r_state == ST_RUN) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end
`else
    assign w_wdog_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_code_nxt  = r_halt_code;
        case (r_state)
            ST_RUN: begin
                // A halt write beats a watchdog expiry in the same cycle.
                if (w_halt_req) begin
                    w_code_nxt = i_ddata;
                    if (DRAIN_CYC == 0) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = c_DRAIN_LOAD;
                    end
                end else if (w_wdog_expire) begin
                    w_state_nxt = ST_WDOG;
                    w_code_nxt  = c_WDOG_CODE;
                end
            end
            ST_DRAIN: begin
                if (r_drain <= 8'd1) begin
                    w_state_nxt = ST_HALTED;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain - 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state     <= ST_RUN;
            r_drain     <= '0;
            r_halt_code <= '0;
        end else if (i_clk_en) begin
            r_state     <= w_state_nxt;
            r_drain     <= w_drain_nxt;
            r_halt_code <= w_code_nxt;
        end
    end

    // Clear takes priority over increment; counters stick at all-ones.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_cyc_cnt <= '0;
            for (int i = 0; i < NCNT; i++) begin
                r_ev_cnt[i] <= '0;
            end
        end else if (i_clk_en) begin
            if (w_clear) begin
                r_cyc_cnt <= '0;
                for (int i = 0; i < NCNT; i++) begin
                    r_ev_cnt[i] <= '0;
                end
            end else if (w_counting) begin
                if (r_cyc_cnt != c_CNT_MAX) begin
                    r_cyc_cnt <= r_cyc_cnt + 1'b1;
                end
                for (int i = 0; i < NCNT; i++) begin
                    if (i_event[i] && (r_ev_cnt[i] != c_CNT_MAX)) begin
                        r_ev_cnt[i] <= r_ev_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_off == '0) begin
            w_rdata[CNT_W-1:0] = r_cyc_cnt;
        end
        for (int i = 0; i < NCNT; i++) begin
            if (w_off == ADDR_W'(i + 1)) begin
                w_rdata[CNT_W-1:0] = r_ev_cnt[i];
            end
        end
        if (w_off == ADDR_W'(c_LAST_OFF)) begin
            w_rdata = {r_state, r_halt_code[DATA_W-3:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (i_clk_en) begin
            r_rvalid <= i_drd && w_in_win;
            if (i_drd && w_in_win) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign o_rdata     = r_rdata;
    assign o_rvalid    = r_rvalid;
    assign o_halt      = (r_state == ST_HALTED) || (r_state == ST_WDOG);
    assign o_halt_code = r_halt_code;
    assign o_state     = r_state;

endmodule
`default_nettype wire
